// File: rtl/page_ctrl_pkg.sv
// rtl/page_ctrl_pkg.sv - page codes, key codes and counter sizing shared by the page_ctrl slice
// Page codes are decoded by the pixel mux and the renderers, so they live here
// rather than inside the FSM.
package page_ctrl_pkg;

  localparam logic [1:0] PAGE_START = 2'b00;
  localparam logic [1:0] PAGE_PLAY  = 2'b01;
  localparam logic [1:0] PAGE_PAUSE = 2'b10;
  localparam logic [1:0] PAGE_OVER  = 2'b11;

  // PS/2 set-2 make code for 'P'
  localparam logic [7:0] KEY_PAUSE = 8'h4D;

  // Bits needed to hold 0..max_val; never less than one bit so a zero limit
  // still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/page_ctrl_if.sv
// rtl/page_ctrl_if.sv - keyboard/game status inputs and page outputs of the page sequencer
// master: the surrounding system (drives events, reads page outputs)
// slave : page_ctrl
//   frame_start  one-cycle pulse per frame
//   key_valid    one-cycle pulse, key_code valid
//   key_code     8-bit make code
//   snake_dead   collision level from game logic
//   page_sel     2-bit page code
//   game_run     high while on the play page
//   game_rst     one-cycle game clear on start->play
//   prompt_on    blink enable for the prompt text
interface page_ctrl_if;
  logic       frame_start;
  logic       key_valid;
  logic [7:0] key_code;
  logic       snake_dead;
  logic [1:0] page_sel;
  logic       game_run;
  logic       game_rst;
  logic       prompt_on;

  modport master (
    output frame_start, key_valid, key_code, snake_dead,
    input  page_sel, game_run, game_rst, prompt_on
  );

  modport slave (
    input  frame_start, key_valid, key_code, snake_dead,
    output page_sel, game_run, game_rst, prompt_on
  );
endinterface

// File: rtl/page_ctrl_frame_divider.sv
// rtl/page_ctrl_frame_divider.sv - frame-driven modulo-N counter with toggle output
// Ports:
//   clk     clock
//   rst     synchronous active-high reset (count 0, toggle 1)
//   clr     synchronous clear to the same values as reset; wins over tick
//   tick    advance one step (normally frame_start, qualified)
//   toggle  registered; flips on the tick that finds the count at N-1
module frame_divider
  import page_ctrl_pkg::*;
#(
  parameter int N = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic toggle
);

  localparam int             W    = cnt_width(N);
  localparam logic [W-1:0]   LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         toggle_q, toggle_d;

  always_comb begin
    cnt_d    = cnt_q;
    toggle_d = toggle_q;
    if (clr) begin
      cnt_d    = '0;
      toggle_d = 1'b1;
    end else if (tick) begin
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        toggle_d = ~toggle_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      toggle_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      toggle_q <= toggle_d;
    end
  end

  assign toggle = toggle_q;

endmodule

// File: rtl/page_ctrl.sv
// rtl/page_ctrl.sv - VGA front-end page sequencer (start/play/pause/over)
// Ports:
//   vga_clk  pixel clock, all logic on the rising edge
//   sys_rst  synchronous active-high reset
//   bus      page_ctrl_if.slave: frame_start, key_valid, key_code, snake_dead in;
//            page_sel, game_run, game_rst, prompt_on out (all registered)
module page_ctrl
  import page_ctrl_pkg::*;
#(
  parameter int         BLINK_FRAMES     = 30,
  parameter int         OVER_HOLD_FRAMES = 120,
  parameter logic [7:0] PAUSE_KEY        = KEY_PAUSE
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  page_ctrl_if.slave  bus
);

  localparam int           HW       = cnt_width(OVER_HOLD_FRAMES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(OVER_HOLD_FRAMES);

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          game_run_q, game_run_d;
  logic          game_rst_q, game_rst_d;
  logic          show_q, show_d;
  logic          hold_done, pause_hit, state_chg, blink_tick, blink_tgl;

  // Keys in OVER only count once the registered hold count is at the limit,
  // so a key landing on the frame that reaches the limit is still dropped.
  assign hold_done = (hold_cnt_q == HOLD_MAX);
  assign pause_hit = bus.key_valid && (bus.key_code == PAUSE_KEY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      PAGE_START: if (bus.key_valid) state_d = PAGE_PLAY;
      PAGE_PLAY: begin
        // collision outranks a simultaneous pause request
        if (bus.snake_dead)  state_d = PAGE_OVER;
        else if (pause_hit)  state_d = PAGE_PAUSE;
      end
      PAGE_PAUSE: if (pause_hit) state_d = PAGE_PLAY;
      default:    if (bus.key_valid && hold_done) state_d = PAGE_START;
    endcase
  end

  assign state_chg = (state_d != state_q);

  // A transition wins over a same-cycle frame: counters take entry values.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_chg)
      hold_cnt_d = '0;
    else if (state_q == PAGE_OVER && bus.frame_start && !hold_done)
      hold_cnt_d = hold_cnt_q + 1'b1;
  end

  assign blink_tick = bus.frame_start &&
                      ((state_q == PAGE_START) || (state_q == PAGE_OVER && hold_done));

  always_comb begin
    game_run_d = (state_d == PAGE_PLAY);
    game_rst_d = (state_q == PAGE_START) && (state_d == PAGE_PLAY);
    show_d     = (state_d == PAGE_START) ||
                 ((state_d == PAGE_OVER) && (hold_cnt_d == HOLD_MAX));
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q    <= PAGE_START;
      hold_cnt_q <= '0;
      game_run_q <= 1'b0;
      game_rst_q <= 1'b0;
      show_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      game_run_q <= game_run_d;
      game_rst_q <= game_rst_d;
      show_q     <= show_d;
    end
  end

  frame_divider #(.N(BLINK_FRAMES)) u_blink (
    .clk    (vga_clk),
    .rst    (sys_rst),
    .clr    (state_chg),
    .tick   (blink_tick),
    .toggle (blink_tgl)
  );

  assign bus.page_sel  = state_q;
  assign bus.game_run  = game_run_q;
  assign bus.game_rst  = game_rst_q;
  // both terms are flops on vga_clk; the prompt is masked off the play pages
  // and during the game-over hold
  assign bus.prompt_on = show_q & blink_tgl;

endmodule

// File: tb/tb_page_ctrl.sv
// tb/tb_page_ctrl.sv - self-checking bench for page_ctrl
module tb_page_ctrl;

  logic vga_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  page_ctrl_if bus ();

  page_ctrl #(
    .BLINK_FRAMES     (30),
    .OVER_HOLD_FRAMES (120),
    .PAUSE_KEY        (8'h4D)
  ) dut (
    .vga_clk (vga_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic       rst;
    logic       frame;
    logic       kv;
    logic [7:0] kc;
    logic       dead;
    logic [1:0] page;
    logic       run;
    logic       grst;
    logic       prompt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic f, input logic kv,
                              input logic [7:0] kc, input logic d,
                              input logic [1:0] p, input logic run,
                              input logic grst, input logic pr, input string nm);
    vec_t v;
    v.rst = r; v.frame = f; v.kv = kv; v.kc = kc; v.dead = d;
    v.page = p; v.run = run; v.grst = grst; v.prompt = pr; v.name = nm;
    return v;
  endfunction

  // Drive one cycle of inputs, let the edge pass, then return inputs to idle.
  task automatic cyc(input logic r, input logic f, input logic kv,
                     input logic [7:0] kc, input logic d);
    sys_rst         = r;
    bus.frame_start = f;
    bus.key_valid   = kv;
    bus.key_code    = kc;
    bus.snake_dead  = d;
    @(posedge vga_clk);
    #1;
    sys_rst         = 1'b0;
    bus.frame_start = 1'b0;
    bus.key_valid   = 1'b0;
    bus.key_code    = 8'h00;
    bus.snake_dead  = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic chk(input string nm, input logic [1:0] p, input logic run,
                     input logic grst, input logic pr);
    n_checks++;
    if ({bus.page_sel, bus.game_run, bus.game_rst, bus.prompt_on} === {p, run, grst, pr})
      n_pass++;
    else
      $display("FAIL %s: got page=%b run=%b rst=%b prompt=%b, expected page=%b run=%b rst=%b prompt=%b",
               nm, bus.page_sel, bus.game_run, bus.game_rst, bus.prompt_on, p, run, grst, pr);
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.key_valid   = 1'b0;
    bus.key_code    = 8'h00;
    bus.snake_dead  = 1'b0;

    //             rst   frm   kv    code   dead  page   run   grst  prompt
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "reset"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "start_idle"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, "start_to_play"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, "game_rst_one_cycle"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h4D, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, "play_to_pause"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, "pause_ignores_dead"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, "pause_ignores_key"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h4D, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, "pause_to_play_no_rst"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, "play_ignores_key"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h4D, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, "b2b_pause_n"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h4D, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, "b2b_pause_n1"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h4D, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "dead_beats_pause"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, "over_key_dropped"));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "reset_in_over_early"));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].frame, vecs[i].kv, vecs[i].kc, vecs[i].dead);
      chk(vecs[i].name, vecs[i].page, vecs[i].run, vecs[i].grst, vecs[i].prompt);
    end

    // OVER hold: 119 frames then a key is dropped; the 120th frame with a key
    // in the same cycle is still dropped; the next key returns to START.
    cyc(1'b0, 1'b0, 1'b1, 8'h1C, 1'b0);
    chk("enter_play", 2'b01, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("enter_over", 2'b11, 1'b0, 1'b0, 1'b0);
    frames(119);
    chk("hold_119_prompt_off", 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h1C, 1'b0);
    chk("hold_119_key_dropped", 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'h1C, 1'b0);
    chk("hold_limit_same_cycle_key", 2'b11, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 8'h29, 1'b0);
    chk("over_to_start", 2'b00, 1'b0, 1'b0, 1'b1);

    // Reset in OVER partway through the hold, then blink from a clean START.
    cyc(1'b0, 1'b0, 1'b1, 8'h1C, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    frames(50);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("reset_in_over", 2'b00, 1'b0, 1'b0, 1'b1);
    frames(29);
    chk("blink_29", 2'b00, 1'b0, 1'b0, 1'b1);
    frames(1);
    chk("blink_30", 2'b00, 1'b0, 1'b0, 1'b0);
    frames(29);
    chk("blink_59", 2'b00, 1'b0, 1'b0, 1'b0);
    frames(1);
    chk("blink_60", 2'b00, 1'b0, 1'b0, 1'b1);

    // Reset in PAUSE, and reset cancelling a pending start->play.
    cyc(1'b0, 1'b0, 1'b1, 8'h1C, 1'b0);
    chk("play_again", 2'b01, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h4D, 1'b0);
    chk("pause_again", 2'b10, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("reset_in_pause", 2'b00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'h1C, 1'b0);
    chk("reset_cancels_game_rst", 2'b00, 1'b0, 1'b0, 1'b1);
    frames(29);
    chk("blink_restart_29", 2'b00, 1'b0, 1'b0, 1'b1);
    frames(1);
    chk("blink_restart_30", 2'b00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/page_ctrl.md
# page_ctrl

Top-level page sequencer for the entertainment system's VGA front end. It tracks which screen is live (start, play, pause, game-over) from keyboard events and game status. It drives the page-select code that the pixel mux uses to choose between the start-page renderer, the game renderer and the game-over renderer. It also generates the game-logic run/reset strobes and the frame-based blink enable for the "PRESS ANY KEY" prompt.

## Interface
Parameters:
- BLINK_FRAMES, 30, frames per prompt blink half-period (1..255)
- OVER_HOLD_FRAMES, 120, frames the game-over page ignores keys (0..1023)
- PAUSE_KEY, 8'h4D, key code that toggles pause (PS/2 set-2 'P')

Ports (one clock; reset is synchronous and active-high):
- vga_clk  in  1  pixel clock, all logic on rising edge
- sys_rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse at start of each frame (vsync edge)
- key_valid  in  1  one-cycle pulse, key_code valid
- key_code  in  8  make code of pressed key
- snake_dead  in  1  level from game logic, high when snake has collided
- page_sel  out  2  00 START, 01 PLAY, 10 PAUSE, 11 OVER
- game_run  out  1  high while page_sel == PLAY (enables snake stepping)
- game_rst  out  1  one-cycle pulse clearing game state on START→PLAY
- prompt_on  out  1  blink enable for prompt text on START/OVER pages

## Operation
- FSM states START, PLAY, PAUSE, OVER; page_sel is the registered state code.
- START: any key_valid → PLAY; game_rst pulses in the same edge as the state change.
- PLAY: snake_dead → OVER, which takes priority over any key. key_valid with key_code==PAUSE_KEY → PAUSE. Other keys are ignored by this block, because the game logic consumes them.
- PAUSE: key_valid with PAUSE_KEY → PLAY with no game_rst. Other keys and snake_dead are ignored.
- OVER: hold_cnt clears on entry and increments on frame_start, saturating at OVER_HOLD_FRAMES. Once hold_cnt==OVER_HOLD_FRAMES, any key_valid → START. Keys before that are dropped and not queued.
- snake_dead is ignored outside PLAY.
- Blink behaviour:
  - blink_cnt and prompt_on load 0 and 1 on every state entry.
  - In START, and in OVER after the hold completes, each frame_start increments blink_cnt.
  - When blink_cnt reaches BLINK_FRAMES-1, blink_cnt wraps to 0 and prompt_on toggles.
  - prompt_on is held 0 in PLAY and PAUSE, and during the OVER hold.
- Counter widths: $clog2(param+1), unsigned. No overflow is possible because both counters saturate or wrap explicitly.

## Timing
- Reset values: page_sel=00, game_run=0, game_rst=0, prompt_on=1, hold_cnt=0, blink_cnt=0.
- All outputs are registered, with 1-cycle latency from the qualifying input cycle to the output change.
- Consecutive-cycle events: when a key_valid arrives in the cycle after a transition, the new state evaluates it. For example, in PLAY, PAUSE_KEY on cycle n then again on n+1 lands back in PLAY at n+2.
- frame_start and key_valid in the same cycle:
  - Both are evaluated.
  - A transition wins: counters take their entry values, not value+1.
- OVER hold exit: a key accepted on the same cycle that hold_cnt reaches OVER_HOLD_FRAMES is not accepted. Acceptance requires the registered count to already equal the limit.
- OVER_HOLD_FRAMES=0: keys are accepted from the cycle after entry.
- Reset mid-operation takes effect on the next edge from any state. It forces START and cancels a pending game_rst.

## Structure
- Page encodings go in shared define.vh as `PAGE_START, `PAGE_PLAY, `PAGE_PAUSE, `PAGE_OVER, because the pixel mux and renderers decode page_sel.
- PAUSE_KEY default goes in define.vh as `KEY_PAUSE.
- One sub-module, frame_divider: a frame_start-driven modulo-N counter with a toggle output and a synchronous clear. It is instantiated for the blink and is reusable for snake step rate.
- Hold counter and FSM stay inline.

## Test plan
- Reset → page_sel=00, prompt_on=1. Apply 30 frame_start pulses → prompt_on=0. After 60 → prompt_on=1.
- START, key_valid code 8'h1C → next cycle page_sel=01, game_run=1, game_rst high exactly 1 cycle.
- PLAY, key 8'h4D → PAUSE (10), game_run=0. Assert snake_dead → still 10. Key 8'h4D → 01 with no game_rst.
- PLAY, snake_dead=1 with key 8'h4D in the same cycle → page_sel=11, not PAUSE, prompt_on=0.
- OVER, OVER_HOLD_FRAMES=120: key after 119 frames → stays 11. After 120 frames key → 00 with prompt_on=1. Same-cycle frame_start and key at the limit-crossing edge → stays 11.
- sys_rst asserted one cycle in PAUSE and in OVER → all outputs at reset values next cycle. Counters restart.
